// File: rtl/imem_loader.sv
// Byte-stream program loader: frames of {count, 4*count big-endian bytes} become
// one instruction RAM write per word. Optional trailer checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_ERROR
    } state_t;

    localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  idx_q,   idx_d;
    logic [1:0]  bcnt_q,  bcnt_d;
    logic [23:0] word_q,  word_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] data_q,  data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q,  csum_d;
`endif

    logic xfer;
    assign xfer = rx_valid && rx_ready;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        bcnt_d   = bcnt_q;
        word_d   = word_q;
        addr_d   = addr_q;
        data_d   = data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        rx_ready = 1'b0;
        wr_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (xfer) begin
                    count_d = rx_data;
                    idx_d   = 8'd0;
                    bcnt_d  = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = rx_data;
`endif
                    if (rx_data == 8'd0 || rx_data > MAX_N) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_RECV;
                    end
                end
            end
            S_RECV: begin
                rx_ready = 1'b1;
                if (xfer) begin
                    word_d = {word_q[15:0], rx_data};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    // The 4th byte completes the word; the write strobe follows next cycle.
                    if (bcnt_q == 2'd3) begin
                        data_d  = {word_q, rx_data};
                        addr_d  = {22'd0, idx_q, 2'b00};
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                wr_en = 1'b1;
                idx_d = idx_q + 8'd1;
                if (idx_q == count_q - 8'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                rx_ready = 1'b1;
                if (xfer) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            S_DONE:  ;
            S_ERROR: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= 8'd0;
            idx_q   <= 8'd0;
            bcnt_q  <= 2'd0;
            word_q  <= 24'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Address/data registers only load on a completed word, so they hold between writes.
    assign wr_addr    = addr_q;
    assign wr_data    = data_q;
    assign cpu_reset  = (state_q != S_DONE);
    assign load_done  = (state_q == S_DONE);
    assign load_error = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random framed byte streams checked every cycle against a
// transaction-level model of the loader, plus literal checks of the directed cases.
module tb_imem_loader;
    localparam int MAXW = 64;
    localparam int M_IDLE = 0, M_RECV = 1, M_CHECK = 2, M_DONE = 3, M_ERR = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready, wr_en, cpu_reset, load_done, load_error;
    logic [31:0] wr_addr, wr_data;

    imem_loader #(.MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_data[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what the loader has seen so far, in frame terms.
    int          m_ph = M_IDLE;
    int          m_n = 0, m_nb = 0, m_words = 0;
    bit          m_wnow = 1'b0;
    bit          m_rdy;
    logic [31:0] m_addr = 32'd0, m_data = 32'd0;
    logic [7:0]  m_csum = 8'd0;
    logic [7:0]  m_buf[$];

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            m_rdy = !m_wnow && (m_ph == M_IDLE || m_ph == M_RECV || m_ph == M_CHECK);
            chk("wr_en", {31'd0, wr_en}, {31'd0, m_wnow});
            chk("rx_ready", {31'd0, rx_ready}, {31'd0, m_rdy});
            chk("load_done", {31'd0, load_done}, {31'd0, m_ph == M_DONE});
            chk("load_error", {31'd0, load_error}, {31'd0, m_ph == M_ERR});
            chk("cpu_reset", {31'd0, cpu_reset}, {31'd0, m_ph != M_DONE});
            chk("wr_addr", wr_addr, m_addr);
            chk("wr_data", wr_data, m_data);
            if (wr_en === 1'b1) begin
                wlog_addr.push_back(wr_addr);
                wlog_data.push_back(wr_data);
            end
            if (reset) begin
                m_ph = M_IDLE; m_n = 0; m_nb = 0; m_words = 0; m_wnow = 1'b0;
                m_addr = 32'd0; m_data = 32'd0; m_csum = 8'd0; m_buf.delete();
            end else begin
                if (m_wnow) begin
                    m_wnow = 1'b0;
                    m_words++;
                    if (m_words == m_n) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        m_ph = M_CHECK;
`else
                        m_ph = M_DONE;
`endif
                    end
                end
                if (rx_valid && m_rdy) begin
                    if (m_ph == M_IDLE) begin
                        m_n = int'(rx_data); m_csum = rx_data; m_nb = 0; m_words = 0;
                        m_buf.delete();
                        m_ph = (m_n == 0 || m_n > MAXW) ? M_ERR : M_RECV;
                    end else if (m_ph == M_RECV) begin
                        m_buf.push_back(rx_data);
                        m_csum ^= rx_data;
                        m_nb++;
                        if (m_nb % 4 == 0) begin
                            m_wnow = 1'b1;
                            m_addr = 32'((m_nb / 4 - 1) * 4);
                            m_data = {m_buf[m_nb-4], m_buf[m_nb-3], m_buf[m_nb-2], m_buf[m_nb-1]};
                        end
                    end else if (m_ph == M_CHECK) begin
                        m_ph = (rx_data == m_csum) ? M_DONE : M_ERR;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t limit=500000", $time);
        $fatal(1, "watchdog expired");
    end

    // All driving happens 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        logic rdy;
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        forever begin
            rdy = rx_ready;
            @(posedge clk); #1;
            if (rdy) break;
            t++;
            if (t > 40) begin
                total++; bad++;
                $display("FAIL send_timeout byte=%h waited=%0d limit=40", b, t);
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int maxgap);
        foreach (s[i]) begin
            idle($urandom_range(0, maxgap));
            send_byte(s[i]);
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        wlog_addr.delete();
        wlog_data.delete();
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] s[$]);
        logic [7:0] x = 8'd0;
        foreach (s[i]) x ^= s[i];
        return x;
    endfunction

    task automatic make_frame(input int n, output logic [7:0] s[$]);
        s.delete();
        s.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom_range(0, 255)));
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(xsum(s));
`endif
    endtask

    task automatic check_t1_log(input string tag);
        logic [31:0] ea[2];
        logic [31:0] ed[2];
        ea[0] = 32'h0; ed[0] = 32'h200400A1;
        ea[1] = 32'h4; ed[1] = 32'h2005005A;
        chk({tag, "_nwr"}, 32'(wlog_addr.size()), 32'd2);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_addr"}, (i < wlog_addr.size()) ? wlog_addr[i] : 32'hDEADBEEF, ea[i]);
            chk({tag, "_data"}, (i < wlog_data.size()) ? wlog_data[i] : 32'hDEADBEEF, ed[i]);
        end
        chk({tag, "_done"}, {31'd0, load_done}, 32'd1);
        chk({tag, "_cpurst"}, {31'd0, cpu_reset}, 32'd0);
    endtask

    logic [7:0] t1[$];
    logic [7:0] fr[$];
    logic [7:0] part[$];

    initial begin
        t1 = '{8'h02, 8'h20, 8'h04, 8'h00, 8'hA1, 8'h20, 8'h05, 8'h00, 8'h5A};
`ifdef IMEM_LOADER_CHECKSUM_EN
        t1.push_back(xsum(t1));
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        reset = 1'b0;

        // Back-to-back two-word program
        send_stream(t1, 0);
        idle(3);
        check_t1_log("t1");

        // Zero count is rejected and the link is then refused
        do_reset();
        send_byte(8'h00);
        idle(2);
        rx_valid = 1'b1; rx_data = 8'h55;
        idle(5);
        rx_valid = 1'b0;
        chk("t2_err", {31'd0, load_error}, 32'd1);
        chk("t2_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("t2_nwr", 32'(wlog_addr.size()), 32'd0);

        // Count one above the limit, then the largest legal program
        do_reset();
        send_byte(8'h41);
        idle(2);
        chk("t3_err", {31'd0, load_error}, 32'd1);
        do_reset();
        make_frame(MAXW, fr);
        send_stream(fr, 0);
        idle(3);
        chk("t3_nwr", 32'(wlog_addr.size()), 32'd64);
        chk("t3_last", (wlog_addr.size() > 0) ? wlog_addr[$] : 32'hDEADBEEF, 32'h000000FC);
        chk("t3_done", {31'd0, load_done}, 32'd1);

        // Same two-word program with random valid gaps
        do_reset();
        send_stream(t1, 5);
        idle(3);
        check_t1_log("t4");

        // Reset in the middle of the second word, then a full reload
        do_reset();
        part = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        send_stream(part, 1);
        chk("t5_nwr", 32'(wlog_data.size()), 32'd1);
        chk("t5_w0", (wlog_data.size() > 0) ? wlog_data[0] : 32'hDEADBEEF, 32'h11223344);
        do_reset();
        chk("t5_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("t5_ready", {31'd0, rx_ready}, 32'd1);
        send_stream(t1, 2);
        idle(3);
        check_t1_log("t5");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong trailer
        do_reset();
        fr = t1;
        fr[fr.size()-1] = 8'h00;
        send_stream(fr, 0);
        idle(2);
        chk("t6_err", {31'd0, load_error}, 32'd1);
        chk("t6_cpurst", {31'd0, cpu_reset}, 32'd1);
`endif

        // Random frames, legal and illegal counts
        for (int k = 0; k < 8; k++) begin
            int n;
            do_reset();
            if ($urandom_range(0, 3) == 0) begin
                n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXW + 1, 255);
                send_byte(8'(n));
                idle(3);
                chk("rnd_err", {31'd0, load_error}, 32'd1);
                chk("rnd_err_nwr", 32'(wlog_addr.size()), 32'd0);
            end else begin
                n = $urandom_range(1, MAXW);
                make_frame(n, fr);
                send_stream(fr, $urandom_range(0, 3));
                idle(3);
                chk("rnd_done", {31'd0, load_done}, 32'd1);
                chk("rnd_nwr", 32'(wlog_addr.size()), 32'(n));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
